// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch unit: default widths, reset vector,
// instruction size and the fetch FSM state encoding.
package pc_fetch_unit_pkg;

  localparam int          DEF_XLEN     = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          INST_BYTES   = 4;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    HOLD       = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_fetch_out_buf.sv
// Decode-side output register plus a one-entry hold slot.
// Flush clears both entries; a held word moves to the output when decode accepts.
module fetch_out_buf
  import pc_fetch_unit_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            wr_valid,
  input  logic [XLEN-1:0] wr_data,
  input  logic [XLEN-1:0] wr_pc,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_data,
  output logic [XLEN-1:0] out_pc
);

  logic            hold_valid;
  logic [XLEN-1:0] hold_q;
  logic [XLEN-1:0] hold_pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_pc     <= '0;
      hold_valid <= 1'b0;
      hold_q     <= '0;
      hold_pc_q  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      hold_valid <= 1'b0;
    end else if (hold_valid) begin
      if (out_ready) begin
        out_data   <= hold_q;
        out_pc     <= hold_pc_q;
        out_valid  <= 1'b1;
        hold_valid <= 1'b0;
      end
    end else if (wr_valid) begin
      // Park the word only when the output is occupied and not draining.
      if (!out_valid || out_ready) begin
        out_data  <= wr_data;
        out_pc    <= wr_pc;
        out_valid <= 1'b1;
      end else begin
        hold_q     <= wr_data;
        hold_pc_q  <= wr_pc;
        hold_valid <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC holder: issues one outstanding imem read at a time, delivers words
// to decode, and handles redirects by flushing buffered and in-flight fetches.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            misalign_err
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            kill_q, kill_d;
  logic            buf_wr;
  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] pc_inc;
  logic            out_free;

  assign redir_pc  = {redirect_pc[XLEN-1:2], 2'b00};
  assign pc_inc    = pc_q + XLEN'(INST_BYTES);
  assign out_free  = !inst_valid || inst_ready;
  assign imem_req  = (state_q == FETCH_WAIT);
  assign imem_addr = addr_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    kill_d  = kill_q;
    buf_wr  = 1'b0;
    unique case (state_q)
      FETCH_IDLE: begin
        state_d = FETCH_WAIT;
        pc_d    = redirect_valid ? redir_pc : pc_q;
        addr_d  = redirect_valid ? redir_pc : pc_q;
      end
      FETCH_WAIT: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            pc_d   = redir_pc;
            addr_d = redir_pc;
            kill_d = 1'b0;
          end else if (kill_q) begin
            // Stale response from before a redirect; refetch the target now.
            kill_d = 1'b0;
            addr_d = pc_q;
          end else if (out_free) begin
            buf_wr = 1'b1;
            pc_d   = pc_inc;
            addr_d = pc_inc;
          end else begin
            buf_wr  = 1'b1;
            state_d = HOLD;
          end
        end else if (redirect_valid) begin
          // Request stays on the bus with its old address until acked.
          pc_d   = redir_pc;
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          addr_d  = redir_pc;
          state_d = FETCH_WAIT;
        end else if (inst_ready) begin
          pc_d    = pc_inc;
          addr_d  = pc_inc;
          state_d = FETCH_WAIT;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH_IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      kill_q       <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      kill_q       <= kill_d;
      misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
    end
  end

  fetch_out_buf #(.XLEN(XLEN)) u_out_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .wr_valid  (buf_wr),
    .wr_data   (imem_rdata),
    .wr_pc     (addr_q),
    .out_ready (inst_ready),
    .out_valid (inst_valid),
    .out_data  (inst_data),
    .out_pc    (inst_pc)
  );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus a randomized run scored
// against an in-order instruction-stream model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  bit          mem_rand;
  int          mem_lat;
  int          cur_lat;
  int          wait_cnt;
  logic [31:0] slow_addr;
  int          slow_lat;
  bit          force_ack;

  always #5 clk = ~clk;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .misalign_err   (misalign_err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
  endfunction

  // Memory responder: acks a request after a per-request latency.
  task automatic mem_step();
    int lat;
    lat = (imem_addr == slow_addr) ? slow_lat : (mem_rand ? cur_lat : mem_lat);
    imem_rdata = mem_word(imem_addr);
    if (force_ack) begin
      imem_ack = 1'b1;
      wait_cnt = 0;
    end else if (imem_req) begin
      if (wait_cnt >= lat) begin
        imem_ack = 1'b1;
        wait_cnt = 0;
        cur_lat  = int'($urandom_range(0, 3));
      end else begin
        imem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mem_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    inst_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    force_ack = 1'b0;
    slow_addr = 32'hFFFF_FFFF;
    slow_lat = 0;
    mem_rand = 1'b0;
    mem_lat = 0;
    cur_lat = 0;
    imem_ack = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    inst_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    force_ack = 1'b0;
    slow_addr = 32'hFFFF_FFFF;
    mem_rand = 1'b0;
    mem_lat = 0;
    imem_ack = 1'b0;
    wait_cnt = 0;
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", imem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", inst_valid); end
    checks++; if (inst_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", inst_data); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 0", inst_pc); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b expected 0", misalign_err); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL early_valid: got %b expected 0", inst_valid); end
    tick();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin errors++; $display("FAIL first_valid: got v=%b pc=%h expected v=1 pc=0", inst_valid, inst_pc); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (k - 1))) begin errors++; $display("FAIL stream_addr[%0d]: got req=%b addr=%h expected addr=%h", k, imem_req, imem_addr, 32'(4 * (k - 1))); end
      if (k >= 2) begin
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * (k - 2)) || inst_data !== mem_word(32'(4 * (k - 2)))) begin errors++; $display("FAIL stream_out[%0d]: got v=%b pc=%h data=%h expected pc=%h", k, inst_valid, inst_pc, inst_data, 32'(4 * (k - 2))); end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (4) tick();
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8 || inst_data !== mem_word(32'h8)) begin errors++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h data=%h expected pc=00000008", i, inst_valid, inst_pc, inst_data); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d]: got %b expected 0", i, imem_req); end
    end
    inst_ready = 1'b1;
    tick();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hC || inst_data !== mem_word(32'hC)) begin errors++; $display("FAIL stall_release: got v=%b pc=%h expected pc=0000000c", inst_valid, inst_pc); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL stall_refetch: got req=%b addr=%h expected addr=00000010", imem_req, imem_addr); end
    tick();
    checks++; if (inst_pc !== 32'h10) begin errors++; $display("FAIL stall_next: got %h expected 00000010", inst_pc); end
    tick();
    checks++; if (inst_pc !== 32'h14) begin errors++; $display("FAIL stall_next2: got %h expected 00000014", inst_pc); end
  endtask

  task automatic test_redirect_kill();
    do_reset();
    slow_addr = 32'h8;
    slow_lat = 3;
    repeat (3) tick();
    checks++; if (imem_addr !== 32'h8 || imem_ack !== 1'b0) begin errors++; $display("FAIL kill_setup: got addr=%h ack=%b expected addr=8 ack=0", imem_addr, imem_ack); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL kill_pending: got v=%b req=%b addr=%h expected v=0 req=1 addr=8", inst_valid, imem_req, imem_addr); end
    tick();
    tick();
    checks++; if (imem_addr !== 32'h8 || imem_ack !== 1'b1) begin errors++; $display("FAIL kill_ack: got addr=%h ack=%b expected addr=8 ack=1", imem_addr, imem_ack); end
    tick();
    checks++; if (inst_valid !== 1'b0 || imem_addr !== 32'h100) begin errors++; $display("FAIL kill_drop: got v=%b addr=%h expected v=0 addr=100", inst_valid, imem_addr); end
    tick();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst_data !== mem_word(32'h100)) begin errors++; $display("FAIL kill_target: got v=%b pc=%h data=%h expected pc=00000100", inst_valid, inst_pc, inst_data); end
    slow_addr = 32'hFFFF_FFFF;
  endtask

  task automatic test_misalign();
    do_reset();
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    tick();
    redirect_valid = 1'b0;
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL misalign_pulse: got %b expected 1", misalign_err); end
    checks++; if (inst_valid !== 1'b0 || imem_addr !== 32'h200) begin errors++; $display("FAIL misalign_addr: got v=%b addr=%h expected v=0 addr=200", inst_valid, imem_addr); end
    tick();
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL misalign_clear: got %b expected 0", misalign_err); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200) begin errors++; $display("FAIL misalign_inst: got v=%b pc=%h expected pc=00000200", inst_valid, inst_pc); end
    tick();
    checks++; if (inst_pc !== 32'h204) begin errors++; $display("FAIL misalign_next: got %h expected 00000204", inst_pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (2) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC || misalign_err !== 1'b0) begin errors++; $display("FAIL wrap_addr0: got addr=%h mis=%b expected addr=fffffffc mis=0", imem_addr, misalign_err); end
    tick();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr1: got v=%b pc=%h addr=%h expected pc=fffffffc addr=0", inst_valid, inst_pc, imem_addr); end
    tick();
    checks++; if (inst_pc !== 32'h0 || inst_data !== mem_word(32'h0) || imem_addr !== 32'h4) begin errors++; $display("FAIL wrap_inst: got pc=%h addr=%h expected pc=0 addr=4", inst_pc, imem_addr); end
  endtask

  task automatic test_reset_mid();
    for (int phase = 0; phase < 2; phase++) begin
      do_reset();
      if (phase == 0) begin
        slow_addr = 32'h8;
        slow_lat = 3;
        repeat (3) tick();
      end else begin
        repeat (2) tick();
        inst_ready = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b1) begin errors++; $display("FAIL mid_hold_setup: got req=%b v=%b expected req=0 v=1", imem_req, inst_valid); end
      end
      rst_n = 1'b0;
      force_ack = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || inst_valid !== 1'b0 || inst_pc !== 32'h0 || inst_data !== 32'h0 || misalign_err !== 1'b0) begin errors++; $display("FAIL mid_rst[%0d]: got req=%b addr=%h v=%b pc=%h data=%h expected all zero", phase, imem_req, imem_addr, inst_valid, inst_pc, inst_data); end
      tick();
      rst_n = 1'b1;
      inst_ready = 1'b1;
      tick();
      checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL mid_late_ack[%0d]: got v=%b req=%b addr=%h expected v=0 req=1 addr=0", phase, inst_valid, imem_req, imem_addr); end
      force_ack = 1'b0;
      slow_addr = 32'hFFFF_FFFF;
      tick();
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== mem_word(32'h0)) begin errors++; $display("FAIL mid_refetch[%0d]: got v=%b pc=%h expected pc=0", phase, inst_valid, inst_pc); end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic        p_valid, p_ready, p_redir, p_req, p_ack;
    logic [31:0] p_pc, p_data, p_tgt, p_addr;
    int          n_xfer;
    do_reset();
    mem_rand = 1'b1;
    exp_pc = 32'h0;
    n_xfer = 0;
    p_valid = 1'b0; p_ready = 1'b0; p_redir = 1'b0; p_req = 1'b0; p_ack = 1'b0;
    p_pc = '0; p_data = '0; p_tgt = '0; p_addr = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (p_valid && !p_ready && !p_redir) begin
        checks++; if (inst_valid !== 1'b1 || inst_pc !== p_pc || inst_data !== p_data) begin errors++; $display("FAIL rnd_stable@%0d: got v=%b pc=%h data=%h expected pc=%h data=%h", cyc, inst_valid, inst_pc, inst_data, p_pc, p_data); end
      end
      if (p_req && !p_ack) begin
        checks++; if (imem_req !== 1'b1 || imem_addr !== p_addr) begin errors++; $display("FAIL rnd_req_hold@%0d: got req=%b addr=%h expected addr=%h", cyc, imem_req, imem_addr, p_addr); end
      end
      checks++; if (misalign_err !== (p_redir && p_tgt[1:0] != 2'b00)) begin errors++; $display("FAIL rnd_misalign@%0d: got %b expected %b", cyc, misalign_err, (p_redir && p_tgt[1:0] != 2'b00)); end
      checks++; if (imem_addr[1:0] !== 2'b00) begin errors++; $display("FAIL rnd_align@%0d: got %h", cyc, imem_addr); end

      inst_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : ($urandom & 32'h0000_3FFF);
      if (inst_valid && inst_ready) begin
        checks++; if (inst_pc !== exp_pc || inst_data !== mem_word(exp_pc)) begin errors++; $display("FAIL rnd_xfer@%0d: got pc=%h data=%h expected pc=%h data=%h", cyc, inst_pc, inst_data, exp_pc, mem_word(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        n_xfer++;
      end
      if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
      p_valid = inst_valid; p_ready = inst_ready; p_redir = redirect_valid;
      p_pc = inst_pc; p_data = inst_data; p_tgt = redirect_pc;
      p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
    end
    redirect_valid = 1'b0;
    checks++; if (n_xfer < 200) begin errors++; $display("FAIL rnd_progress: got %0d transfers expected at least 200", n_xfer); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_kill();
    test_misalign();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
